// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Serves MIPS mult/multu/div/divu/mthi/mtlo beside the EX-stage ALU.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   start - issue request, sampled on the rising edge
//   op    - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   a, b  - rs / rt operands, captured when a mult/div is accepted
//   flush - cancels an in-flight operation; blocks any issue while idle
//   busy  - operation in flight (hazard unit stalls mfhi/mflo and new issue)
//   done  - one-cycle pulse on the cycle HI/LO commit
//   hi,lo - HI / LO registers
module mul_div_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic { IDLE, RUN } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra, rb;
    logic             div_q;   // captured op is a divide
    logic             uns_q;   // captured op is unsigned

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, divisor, quo_mag, rem_mag;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Extending to 2*WIDTH first lets one multiplier serve both signednesses:
    // the low 2*WIDTH bits of the product are correct either way.
    always_comb begin
        a_ext = uns_q ? {{WIDTH{1'b0}}, ra} : {{WIDTH{ra[WIDTH-1]}}, ra};
        b_ext = uns_q ? {{WIDTH{1'b0}}, rb} : {{WIDTH{rb[WIDTH-1]}}, rb};
        prod  = a_ext * b_ext;
    end

    // Signed divide on magnitudes, then restore signs. The overflow case
    // (most-negative / -1) falls out naturally: its magnitude quotient is
    // 2^(WIDTH-1), which is already the required bit pattern.
    always_comb begin
        neg_a   = !uns_q && ra[WIDTH-1];
        neg_b   = !uns_q && rb[WIDTH-1];
        mag_a   = neg_a ? -ra : ra;
        mag_b   = neg_b ? -rb : rb;
        divisor = (rb == '0) ? WIDTH'(1) : mag_b;
        quo_mag = mag_a / divisor;
        rem_mag = mag_a % divisor;
    end

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_q) begin
            if (rb == '0) begin
                res_lo = '1;
                res_hi = ra;
            end else begin
                res_lo = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
                res_hi = neg_a ? -rem_mag : rem_mag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            ra    <= '0;
            rb    <= '0;
            div_q <= 1'b0;
            uns_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                ra    <= a;
                                rb    <= b;
                                div_q <= op[1];
                                uns_q <= op[0];
                                cnt   <= op[1] ? CW'(DIV_LAT) : CW'(MUL_LAT);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        cnt   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          flush;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    mul_div_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic void ref_result(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y,
                                       output logic [31:0] rh, output logic [31:0] rl);
        longint          ps;
        longint unsigned pu;
        int              sx, sy;
        case (o)
            3'b000: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                rh = ps[63:32]; rl = ps[31:0];
            end
            3'b001: begin
                pu = {32'h0, x} * {32'h0, y};
                rh = pu[63:32]; rl = pu[31:0];
            end
            default: begin
                if (y == 0) begin
                    rl = 32'hFFFFFFFF; rh = x;
                end else if (o == 3'b010) begin
                    if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                        rl = 32'h80000000; rh = 0;
                    end else begin
                        sx = $signed(x); sy = $signed(y);
                        rl = sx / sy; rh = sx % sy;
                    end
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
        endcase
    endfunction

    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    bit          m_busy = 0, m_done = 0;
    int          cyc = 0, due = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0;
        end else begin
            cyc++;
            m_done = 0;
            if (m_busy) begin
                if (flush) m_busy = 0;
                else if (cyc == due) begin
                    m_hi = p_hi; m_lo = p_lo; m_busy = 0; m_done = 1;
                end
            end else if (start && !flush) begin
                if (op <= 3'b011) begin
                    ref_result(op, a, b, p_hi, p_lo);
                    due = cyc + ((op[1]) ? DL : ML);
                    m_busy = 1;
                end else if (op == 3'b100) m_hi = a;
                else if (op == 3'b101) m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; op = 3'b111;
    endtask

    task automatic wait_done(output int nbusy);
        bit got;
        nbusy = 0; got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin got = 1; break; end
        end
        check("done_seen", 64'(got), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int nb, nd;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b111; a = 0; b = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        issue(3'b001, 32'hFFFFFFFF, 32'h2);
        wait_done(nb);
        check("multu_busy_cycles", 64'(nb), 64'd5);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFFFFFE);

        tick(); issue(3'b000, 32'hFFFFFFFD, 32'h5); wait_done(nb);
        check("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo), 64'hFFFFFFF1);
        tick(); issue(3'b001, 32'hFFFFFFFD, 32'h5); wait_done(nb);
        check("multu2_hi", 64'(hi), 64'h4);
        check("multu2_lo", 64'(lo), 64'hFFFFFFF1);

        tick(); issue(3'b010, 32'hFFFFFFF9, 32'h2); wait_done(nb);
        check("div_busy_cycles", 64'(nb), 64'd10);
        check("div_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_hi", 64'(hi), 64'hFFFFFFFF);
        tick(); issue(3'b010, 32'h80000000, 32'hFFFFFFFF); wait_done(nb);
        check("divovf_lo", 64'(lo), 64'h80000000);
        check("divovf_hi", 64'(hi), 64'h0);
        tick(); issue(3'b011, 32'h7, 32'h0); wait_done(nb);
        check("divu0_lo", 64'(lo), 64'hFFFFFFFF);
        check("divu0_hi", 64'(hi), 64'h7);

        tick();
        issue(3'b100, 32'h1234, 32'h0);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(3'b101, 32'h5678, 32'h0);
        check("mtlo_lo", 64'(lo), 64'h5678);
        check("mtlo_busy", 64'(busy), 64'd0);

        // divu then flush on the third cycle of RUN
        issue(3'b011, 32'd100, 32'd7);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234);
        check("flush_lo", 64'(lo), 64'h5678);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush_no_done", 64'(nd), 64'd0);

        // mtlo issued during RUN is ignored
        tick();
        issue(3'b001, 32'd3, 32'd4);
        tick();
        issue(3'b101, 32'hAAAA, 32'h0);
        wait_done(nb);
        check("ign_hi", 64'(hi), 64'h0);
        check("ign_lo", 64'(lo), 64'd12);

        // asynchronous reset mid-operation
        tick();
        issue(3'b001, 32'd3, 32'd4);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            start = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            a     = pick();
            b     = pick();
            flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end
        start = 1'b0; flush = 1'b0;
        repeat (15) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It runs beside the single-cycle ALU in the EX stage and serves MIPS mult/multu/div/divu/mthi/mtlo. Operands are captured on start. busy holds until the result is committed, so the hazard unit can stall mfhi/mflo and any new mult/div issue.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (≥ 8)
MUL_LAT, 5, cycles from accepted mult/multu to HI/LO commit (≥ 1)
DIV_LAT, 10, cycles from accepted div/divu to HI/LO commit (≥ 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  issue request, sampled on the rising edge
op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others = no-op
a  input  WIDTH  rs operand (multiplicand / dividend / mthi,mtlo source)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  cancels an in-flight operation (exception or branch squash)
busy  output  1  operation in flight
done  output  1  one-cycle pulse on the cycle HI/LO commit
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, immediate): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Reset mid-operation discards the operation.
- States are IDLE and RUN.
- IDLE, start=1, flush=0, op∈{mult,multu,div,divu}:
  - Latch a, b and op.
  - Load counter with MUL_LAT or DIV_LAT.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=mthi/mtlo: hi/lo ← a at that edge. busy stays 0, done stays 0.
- IDLE, start with undefined op: ignored.
- RUN: counter decrements each edge. On the edge where it reaches 0:
  - hi/lo commit.
  - busy=0, done=1 for one cycle.
  - Return to IDLE.
- Timing: busy is high for exactly LAT cycles. A start accepted at edge N commits at edge N+LAT.
- RUN, start=1 (any op, including mthi/mtlo): ignored. The hazard unit must stall instead.
- flush=1 in RUN:
  - Next edge returns to IDLE, busy=0, no done.
  - hi/lo keep their pre-operation values.
- flush=1 in IDLE: any simultaneous start, including mthi/mtlo, is ignored. Flush wins.
- Reset while flush or start is asserted: reset wins.
- Multiply: full 2·WIDTH-bit product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - mult treats a and b as two's complement.
  - multu treats them as unsigned.
- Divide: lo = quotient, hi = remainder.
  - div truncates toward zero; the remainder takes the sign of the dividend.
  - divu is unsigned.
- Divide by zero (b=0): lo = all ones, hi = a, for both div and divu. Latency is unchanged.
- Signed overflow, div with a = −2^(WIDTH−1) and b = −1: lo = −2^(WIDTH−1), hi = 0.
- Captured operands are used throughout. Changes on a/b during RUN have no effect.
- hi/lo change only at commit, on mthi/mtlo, or on reset. They hold their previous values throughout RUN.
- Over/exception flags are not generated; MIPS mult/div never trap.

Test Plan:
- multu a=0xFFFFFFFF, b=0x2 → busy high 5 cycles, then done pulse; hi=0x00000001, lo=0xFFFFFFFE.
- mult a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with multu → hi=0x00000004, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- Preload: mthi 0x1234, then mtlo 0x5678 in IDLE → each takes effect next edge with busy=0.
  - Then start divu a=100, b=7, and at cycle 3 assert flush → busy drops next edge, no done, hi=0x1234, lo=0x5678.
- Start multu a=3, b=4; at cycle 2 issue start with mtlo a=0xAAAA → ignored; after commit hi=0, lo=12.
  - Repeat, asserting reset at cycle 2 → hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
